// File: rtl/pc_next_unit.sv
// Program-counter stage of the Mini RISC core: next-PC selection, halt/resume
// control and a saturating taken-branch counter for debug visibility.
module pc_next_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [5:0]  opcode,
  input  logic        is_branch,
  input  logic [15:0] branch_offset,
  input  logic        resume,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        halted,
  output logic [15:0] taken_cnt
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc_next;
  logic [15:0] cnt_next;
  logic [29:0] offset_words;
  logic [31:0] branch_target;

  assign pc_plus4      = pc_out + 32'd4;
  assign offset_words  = {{14{branch_offset[15]}}, branch_offset};
  assign branch_target = pc_plus4 + {offset_words, 2'b00};

  // NOTE: every signal gets its hold value first so no path through the
  // decision tree leaves one unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    pc_next    = pc_out;
    cnt_next   = taken_cnt;
    if (!stall) begin
      case (state)
        RUN: begin
          // A halt leaves pc_out on the halt instruction itself.
          if (opcode == HALT_OPCODE) begin
            state_next = HALTED;
          end else if (is_branch) begin
            pc_next = branch_target;
            if (taken_cnt != 16'hFFFF) cnt_next = taken_cnt + 16'd1;
          end else begin
            pc_next = pc_plus4;
          end
        end
        HALTED: begin
          if (resume) begin
            pc_next    = pc_plus4;
            state_next = RUN;
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      pc_out    <= RESET_PC;
      taken_cnt <= 16'd0;
    end else begin
      state     <= state_next;
      pc_out    <= pc_next;
      taken_cnt <= cnt_next;
    end
  end

  assign halted = (state == HALTED);

endmodule
